// File: rtl/if_id_ctrl_pkg.sv
// Shared types and constants for the IF/ID pipeline register and its control.
package if_id_ctrl_pkg;

  // Control FSM states; encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Bubble instruction loaded into IF/ID on a squash.
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: pc/instr/valid with flush taking priority over freeze.
module if_id_reg
  import if_id_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              valid
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;

  // Next-value selection: squash, hold, or capture the fetched word.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = DATA_W'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  // Register update with synchronous reset to an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= DATA_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID register plus hazard stall, branch redirect/squash control and perf counters.
module if_id_ctrl
  import if_id_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_AW       = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              exe_wb_en,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              exe_br_req,
  input  logic [DATA_W-1:0] exe_br_addr,
  output logic              freeze,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic              id_ex_flush,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  output logic              id_valid,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned FC_W        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hazard;
  logic              squash;

  // RAW hazard of the ID instruction against EXE and MEM writers.
  always_comb begin
    hazard = id_valid &
             ((exe_wb_en & ((exe_dest == id_src1) | (id_two_src & (exe_dest == id_src2)))) |
              (mem_wb_en & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)))));
  end

  // Same-cycle fetch control; a taken branch overrides the stall.
  always_comb begin
    branch_taken = exe_br_req;
    branch_addr  = exe_br_addr;
    id_ex_flush  = exe_br_req;
    freeze       = hazard & ~exe_br_req;
    squash       = exe_br_req | (state_q == ST_FLUSH);
  end

  if_id_reg #(
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (squash),
    .freeze   (freeze),
    .pc_in    (if_pc),
    .instr_in (if_instr),
    .pc       (id_pc),
    .instr    (id_instr),
    .valid    (id_valid)
  );

  // Next-state logic: redirects enter FLUSH (when multi-cycle), hazards enter STALL.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (exe_br_req) begin
          if (MULTI_FLUSH) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (hazard) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (exe_br_req) begin
          fcnt_d = FC_RELOAD;
        end else if (fcnt_q <= FC_W'(1)) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // Saturating stall/redirect counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (exe_br_req && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed-vector bench with a scoreboard queue; a negedge monitor pops and checks.
module tb_if_id_ctrl;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc, if_instr, exe_br_addr;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_two_src, exe_wb_en, mem_wb_en, exe_br_req;

  logic        freeze, branch_taken, id_ex_flush, id_valid;
  logic [31:0] branch_addr, id_pc, id_instr, stall_cnt, flush_cnt;
  logic [1:0]  state;

  logic        freeze3, branch_taken3, id_ex_flush3, id_valid3;
  logic [31:0] branch_addr3, id_pc3, id_instr3;
  logic [1:0]  state3;
  logic [2:0]  stall_cnt3, flush_cnt3;

  always #5 clk = ~clk;

  if_id_ctrl #(.DATA_W(32), .REG_AW(4), .FLUSH_CYCLES(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .exe_br_req(exe_br_req), .exe_br_addr(exe_br_addr),
    .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .id_ex_flush(id_ex_flush), .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_ctrl #(.DATA_W(32), .REG_AW(4), .FLUSH_CYCLES(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .exe_br_req(exe_br_req), .exe_br_addr(exe_br_addr),
    .freeze(freeze3), .branch_taken(branch_taken3), .branch_addr(branch_addr3),
    .id_ex_flush(id_ex_flush3), .id_pc(id_pc3), .id_instr(id_instr3), .id_valid(id_valid3),
    .state(state3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
  );

  typedef struct {
    int          id;
    logic        rst;
    logic [31:0] pc;
    logic [3:0]  s1, s2, ed, md;
    logic        two, ewb, mwb, br;
    logic [31:0] ba;
    logic        e_frz, e_bt, e_fl;
    logic [31:0] e_ba;
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_sc, e_fc;
    logic [1:0]  e_st;
    logic        chk3, e3_valid;
    logic [1:0]  e3_st;
    logic        chk3c;
    logic [2:0]  e3_sc, e3_fc;
  } vec_t;

  vec_t v;
  vec_t q[$];
  int   step = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic drv(input logic r, input logic [31:0] pc,
                     input logic [3:0] s1, input logic [3:0] s2, input logic two,
                     input logic ewb, input logic [3:0] ed,
                     input logic mwb, input logic [3:0] md,
                     input logic br, input logic [31:0] ba);
    v.rst = r; v.pc = pc; v.s1 = s1; v.s2 = s2; v.two = two;
    v.ewb = ewb; v.ed = ed; v.mwb = mwb; v.md = md; v.br = br; v.ba = ba;
    v.chk3 = 1'b0; v.e3_valid = 1'b0; v.e3_st = S_RUN;
    v.chk3c = 1'b0; v.e3_sc = 3'd0; v.e3_fc = 3'd0;
  endtask

  task automatic expc(input logic f, input logic bt, input logic fl, input logic [31:0] ba);
    v.e_frz = f; v.e_bt = bt; v.e_fl = fl; v.e_ba = ba;
  endtask

  task automatic expr(input logic val, input logic [31:0] pc, input logic [1:0] st,
                      input logic [31:0] sc, input logic [31:0] fc);
    v.e_valid = val; v.e_pc = pc; v.e_instr = val ? instr_of(pc) : 32'h0;
    v.e_st = st; v.e_sc = sc; v.e_fc = fc;
  endtask

  task automatic exp3(input logic val, input logic [1:0] st);
    v.chk3 = 1'b1; v.e3_valid = val; v.e3_st = st;
  endtask

  task automatic exp3c(input logic [2:0] sc, input logic [2:0] fc);
    v.chk3c = 1'b1; v.e3_sc = sc; v.e3_fc = fc;
  endtask

  // Apply one vector just after the edge and queue its expectations.
  task automatic issue();
    @(posedge clk);
    #1;
    rst = v.rst; if_pc = v.pc; if_instr = instr_of(v.pc);
    id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
    exe_wb_en = v.ewb; exe_dest = v.ed; mem_wb_en = v.mwb; mem_dest = v.md;
    exe_br_req = v.br; exe_br_addr = v.ba;
    v.id = step;
    step++;
    q.push_back(v);
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL step%0d %s got %h exp %h", id, nm, got, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation.
  always @(negedge clk) begin
    vec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.id, "freeze",       32'(freeze),       32'(e.e_frz));
      chk(e.id, "branch_taken", 32'(branch_taken), 32'(e.e_bt));
      chk(e.id, "id_ex_flush",  32'(id_ex_flush),  32'(e.e_fl));
      chk(e.id, "branch_addr",  branch_addr,       e.e_ba);
      chk(e.id, "id_valid",     32'(id_valid),     32'(e.e_valid));
      chk(e.id, "id_pc",        id_pc,             e.e_pc);
      chk(e.id, "id_instr",     id_instr,          e.e_instr);
      chk(e.id, "state",        32'(state),        32'(e.e_st));
      chk(e.id, "stall_cnt",    stall_cnt,         e.e_sc);
      chk(e.id, "flush_cnt",    flush_cnt,         e.e_fc);
      if (e.chk3) begin
        chk(e.id, "fc3_id_valid", 32'(id_valid3), 32'(e.e3_valid));
        chk(e.id, "fc3_state",    32'(state3),    32'(e.e3_st));
      end
      if (e.chk3c) begin
        chk(e.id, "fc3_stall_cnt", 32'(stall_cnt3), 32'(e.e3_sc));
        chk(e.id, "fc3_flush_cnt", 32'(flush_cnt3), 32'(e.e3_fc));
      end
    end
  end

  initial begin
    rst = 1'b1; if_pc = '0; if_instr = '0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    exe_wb_en = 1'b0; exe_dest = '0; mem_wb_en = 1'b0; mem_dest = '0;
    exe_br_req = 1'b0; exe_br_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(0, 0, S_RUN, 0, 0);
    exp3(0, S_RUN); exp3c(0, 0); issue();
    // Unhazarded fetches 1,2,3
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(0, 0, S_RUN, 0, 0); issue();
    drv(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 1, S_RUN, 0, 0); issue();
    drv(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 2, S_RUN, 0, 0); issue();
    // EXE then MEM hazard on src1=3
    drv(0, 4, 3, 0, 0, 1, 3, 0, 0, 0, 0); expc(1, 0, 0, 0); expr(1, 3, S_RUN, 0, 0); issue();
    drv(0, 4, 3, 0, 0, 0, 0, 1, 3, 0, 0); expc(1, 0, 0, 0); expr(1, 3, S_STALL, 1, 0); issue();
    drv(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 3, S_STALL, 2, 0); issue();
    // src2 only counts when id_two_src is set
    drv(0, 5, 1, 5, 0, 0, 0, 1, 5, 0, 0); expc(0, 0, 0, 0); expr(1, 4, S_RUN, 2, 0); issue();
    drv(0, 6, 1, 5, 1, 0, 0, 1, 5, 0, 0); expc(1, 0, 0, 0); expr(1, 5, S_RUN, 2, 0); issue();
    // Branch during active hazard, then a second branch the next cycle
    drv(0, 6, 1, 5, 1, 0, 0, 1, 5, 1, 32'h40); expc(0, 1, 1, 32'h40); expr(1, 5, S_STALL, 3, 0); issue();
    drv(0, 32'h41, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80); expc(0, 1, 1, 32'h80); expr(0, 0, S_RUN, 3, 1);
    exp3(0, S_FLUSH); issue();
    drv(0, 32'h81, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(0, 0, S_RUN, 3, 2);
    exp3(0, S_FLUSH); issue();
    drv(0, 32'h82, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 32'h81, S_RUN, 3, 2);
    exp3(0, S_FLUSH); issue();
    drv(0, 32'h83, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 32'h82, S_RUN, 3, 2);
    exp3(0, S_RUN); issue();
    drv(0, 32'h84, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 32'h83, S_RUN, 3, 2);
    exp3(1, S_RUN); issue();
    // Long stall: drives the 3-bit stall counter into saturation
    for (int k = 0; k < 5; k++) begin
      drv(0, 32'h85, 3, 0, 0, 1, 3, 0, 0, 0, 0); expc(1, 0, 0, 0);
      expr(1, 32'h84, (k == 0) ? S_RUN : S_STALL, 32'(3 + k), 2); issue();
    end
    // Reset asserted while stalled
    drv(1, 32'h85, 3, 0, 0, 1, 3, 0, 0, 0, 0); expc(1, 0, 0, 0); expr(1, 32'h84, S_STALL, 8, 2);
    exp3(1, S_STALL); exp3c(7, 2); issue();
    drv(0, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(0, 0, S_RUN, 0, 0);
    exp3(0, S_RUN); exp3c(0, 0); issue();
    // Back-to-back branches: 3-bit flush counter saturates
    for (int k = 0; k < 8; k++) begin
      drv(0, 32'h91, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100); expc(0, 1, 1, 32'h100);
      expr(k == 0, (k == 0) ? 32'h90 : 32'h0, S_RUN, 0, 32'(k)); issue();
    end
    drv(0, 32'h92, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(0, 0, S_RUN, 0, 8);
    exp3(0, S_FLUSH); exp3c(0, 7); issue();
    drv(0, 32'h93, 0, 0, 0, 0, 0, 0, 0, 0, 0); expc(0, 0, 0, 0); expr(1, 32'h92, S_RUN, 0, 8); issue();

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending %0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
